// File: rtl/aska_hbridge_driver.sv
// aska_hbridge_driver: H-bridge switch and current-DAC driver.
// Registers the raw switch/DAC requests and applies break-before-make dead time
// between switch patterns. The DAC stays disabled until the switches have
// settled. A shoot-through request latches a fault that holds the bridge open
// until it is cleared.
// Optional feature: define DRIVE_WATCHDOG_EN to fault a DRIVE phase that lasts
// MAX_DRIVE_CYCLES cycles.
module aska_hbridge_driver #(
  parameter int N_ELEC           = 32,
  parameter int DAC_W            = 6,
  parameter int DEAD_CYCLES      = 2,
  parameter int SETTLE_CYCLES    = 1,
  parameter int MAX_DRIVE_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_ELEC-1:0] up_req,
  input  logic [N_ELEC-1:0] down_req,
  input  logic [DAC_W-1:0]  dac_req,
  input  logic              fault_clear,
  output logic [N_ELEC-1:0] up_drv,
  output logic [N_ELEC-1:0] down_drv,
  output logic [DAC_W-1:0]  dac_out,
  output logic              dac_en,
  output logic              fault,
  output logic [15:0]       pulse_count
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] DEAD_LOAD   = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DEAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_DRIVE  = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t                r_state;
  logic [N_ELEC-1:0]     r_up_q;
  logic [N_ELEC-1:0]     r_down_q;
  logic [DAC_W-1:0]      r_dac_q;
  logic [2*N_ELEC-1:0]   r_pattern;
  logic [CNT_W-1:0]      r_cnt;
  logic [N_ELEC-1:0]     r_up_drv;
  logic [N_ELEC-1:0]     r_down_drv;
  logic [DAC_W-1:0]      r_dac_out;
  logic                  r_dac_en;
  logic                  r_fault;
  logic [15:0]           r_pulse_count;

  logic [2*N_ELEC-1:0]   w_target;
  logic                  w_active;
  logic                  w_shoot;
  logic                  w_wd_trip;

  // Saturating pulse counter increment.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_target = {r_up_q, r_down_q};
  assign w_active = |w_target;
  assign w_shoot  = |(r_up_q & r_down_q);

`ifdef DRIVE_WATCHDOG_EN
  localparam int WD_W = $clog2(MAX_DRIVE_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_DRIVE_CYCLES - 1);
  logic [WD_W-1:0] r_wd_cnt;

  // Count consecutive DRIVE cycles; any other state restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_DRIVE) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign w_wd_trip = (r_state == S_DRIVE) && (r_wd_cnt >= WD_LAST);
`else
  assign w_wd_trip = 1'b0;
`endif

  // Input stage: the FSM only ever looks at these registered requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_up_q   <= '0;
      r_down_q <= '0;
      r_dac_q  <= '0;
    end else begin
      r_up_q   <= up_req;
      r_down_q <= down_req;
      r_dac_q  <= dac_req;
    end
  end

  // Bridge sequencing FSM with registered drive outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pattern     <= '0;
      r_cnt         <= '0;
      r_up_drv      <= '0;
      r_down_drv    <= '0;
      r_dac_out     <= '0;
      r_dac_en      <= 1'b0;
      r_fault       <= 1'b0;
      r_pulse_count <= 16'd0;
    end else if (w_shoot || w_wd_trip) begin
      // Shoot-through (or stuck drive) wins over every other transition.
      r_state    <= S_FAULT;
      r_fault    <= 1'b1;
      r_up_drv   <= '0;
      r_down_drv <= '0;
      r_dac_out  <= '0;
      r_dac_en   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_up_drv   <= '0;
          r_down_drv <= '0;
          r_dac_out  <= '0;
          r_dac_en   <= 1'b0;
          if (w_active) begin
            r_cnt   <= DEAD_LOAD;
            r_state <= S_DEAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DEAD: begin
          r_dac_out <= '0;
          r_dac_en  <= 1'b0;
          if (r_cnt != '0) begin
            r_cnt      <= r_cnt - CNT_W'(1);
            r_up_drv   <= '0;
            r_down_drv <= '0;
          end else if (w_active) begin
            // Whatever target is present on the last dead cycle is applied.
            r_pattern  <= w_target;
            r_up_drv   <= r_up_q;
            r_down_drv <= r_down_q;
            r_cnt      <= SETTLE_LOAD;
            r_state    <= S_SETTLE;
          end else begin
            r_up_drv   <= '0;
            r_down_drv <= '0;
            r_state    <= S_IDLE;
          end
        end
        S_SETTLE: begin
          r_dac_out <= '0;
          if (w_target != r_pattern) begin
            r_up_drv   <= '0;
            r_down_drv <= '0;
            r_dac_en   <= 1'b0;
            r_cnt      <= DEAD_LOAD;
            r_state    <= S_DEAD;
          end else if (r_cnt == '0) begin
            r_dac_en      <= 1'b1;
            r_dac_out     <= r_dac_q;
            r_pulse_count <= sat_inc(r_pulse_count);
            r_state       <= S_DRIVE;
          end else begin
            r_dac_en <= 1'b0;
            r_cnt    <= r_cnt - CNT_W'(1);
          end
        end
        S_DRIVE: begin
          if (w_target != r_pattern) begin
            // DAC and switches drop together; the next pattern waits a full dead time.
            r_up_drv   <= '0;
            r_down_drv <= '0;
            r_dac_out  <= '0;
            r_dac_en   <= 1'b0;
            r_cnt      <= DEAD_LOAD;
            r_state    <= S_DEAD;
          end else begin
            r_dac_out <= r_dac_q;
            r_dac_en  <= 1'b1;
          end
        end
        S_FAULT: begin
          r_up_drv   <= '0;
          r_down_drv <= '0;
          r_dac_out  <= '0;
          r_dac_en   <= 1'b0;
          if (fault_clear && !w_active) begin
            r_fault <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_fault <= 1'b1;
          end
        end
        default: begin
          // An illegal state encoding is treated as a fault.
          r_up_drv   <= '0;
          r_down_drv <= '0;
          r_dac_out  <= '0;
          r_dac_en   <= 1'b0;
          r_fault    <= 1'b1;
          r_state    <= S_FAULT;
        end
      endcase
    end
  end

  assign up_drv      = r_up_drv;
  assign down_drv    = r_down_drv;
  assign dac_out     = r_dac_out;
  assign dac_en      = r_dac_en;
  assign fault       = r_fault;
  assign pulse_count = r_pulse_count;

endmodule
